baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 118 +++++++++++
 tb/tb_baud_gen_frac.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional-N UART baud generator: a phase accumulator produces os_tick, bit_tick and os_count.
// Outputs are registered one cycle after the overflowing edge; there is no backpressure, and enable gates generation.
module baud_gen_frac #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [2:0]                    baud_sel,
    input  logic                          sync_clr,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_count
);
    typedef longint unsigned u64_t;
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

    function automatic u64_t calc_inc(input int unsigned rate);
        u64_t num;
        num = (u64_t'(rate) * u64_t'(OVERSAMPLE)) << ACC_W;
        return (num + u64_t'(CLK_HZ / 2)) / u64_t'(CLK_HZ);
    endfunction

    function automatic bit inc_bad(input u64_t v);
        return (v == 0) || (v >= (u64_t'(1) << (ACC_W - 1)));
    endfunction

    localparam u64_t INC0 = calc_inc(9600);
    localparam u64_t INC1 = calc_inc(19200);
    localparam u64_t INC2 = calc_inc(38400);
    localparam u64_t INC3 = calc_inc(57600);
    localparam u64_t INC4 = calc_inc(115200);
    localparam u64_t INC5 = calc_inc(230400);
    localparam u64_t INC6 = calc_inc(460800);
    localparam u64_t INC7 = calc_inc(921600);

    // An increment below half scale guarantees at most one overflow per two edges.
    localparam bit INC_BAD = inc_bad(INC0) || inc_bad(INC1) || inc_bad(INC2) || inc_bad(INC3) ||
                             inc_bad(INC4) || inc_bad(INC5) || inc_bad(INC6) || inc_bad(INC7);
    localparam bit CFG_BAD = (OVERSAMPLE < 4) || (OVERSAMPLE > 64) ||
                             ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0) ||
                             (ACC_W < 9) || (ACC_W > 37);

    if (INC_BAD || CFG_BAD) begin : g_bad_cfg
        $error("baud_gen_frac: illegal OVERSAMPLE/ACC_W or increment out of range for CLK_HZ");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic [2:0]       sel_q, sel_d;
    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             clr;

    always_comb begin
        inc_sel = INC0[ACC_W-1:0];
        case (sel_q)
            3'd1:    inc_sel = INC1[ACC_W-1:0];
            3'd2:    inc_sel = INC2[ACC_W-1:0];
            3'd3:    inc_sel = INC3[ACC_W-1:0];
            3'd4:    inc_sel = INC4[ACC_W-1:0];
            3'd5:    inc_sel = INC5[ACC_W-1:0];
            3'd6:    inc_sel = INC6[ACC_W-1:0];
            3'd7:    inc_sel = INC7[ACC_W-1:0];
            default: inc_sel = INC0[ACC_W-1:0];
        endcase
    end

    assign sum   = {1'b0, acc_q} + {1'b0, inc_sel};
    assign carry = sum[ACC_W];
    // A new rate realigns phase so no tick is ever derived from two different increments.
    assign clr   = sync_clr || (baud_sel != sel_q);

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        sel_d      = baud_sel;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (enable) begin
            acc_d     = sum[ACC_W-1:0];
            os_tick_d = carry;
            if (carry) begin
                cnt_d      = cnt_q + CNT_W'(1);
                bit_tick_d = (cnt_q == CNT_W'(OVERSAMPLE - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            sel_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            sel_q      <= sel_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign os_count = cnt_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: a cycle model pushes expected outputs each edge; tests pop and compare at negedge.
module tb_baud_gen_frac;
    localparam int OS = 16;
    localparam int CW = 4;
    localparam longint TWO32 = longint'(1) << 32;

    typedef struct packed {
        logic          os;
        logic          bt;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          enable   = 1'b0;
    logic          sync_clr = 1'b0;
    logic [2:0]    baud_sel = 3'd0;
    logic          os_tick;
    logic          bit_tick;
    logic [CW-1:0] os_count;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    int unsigned rates [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    longint      m_inc [8];
    longint      m_acc = 0;
    int          m_cnt = 0;
    logic [2:0]  m_sel = 3'd0;

    baud_gen_frac #(.CLK_HZ(100_000_000), .OVERSAMPLE(OS), .ACC_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .baud_sel (baud_sel),
        .sync_clr (sync_clr),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .os_count (os_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin : model
        exp_t nx;
        if (!reset_n) begin
            m_acc = 0;
            m_cnt = 0;
            m_sel = 3'd0;
            exp_q.delete();
        end else begin
            nx = '0;
            if (sync_clr || (baud_sel != m_sel)) begin
                m_acc = 0;
                m_cnt = 0;
            end else if (enable) begin
                m_acc = m_acc + m_inc[m_sel];
                if (m_acc >= TWO32) begin
                    m_acc  = m_acc - TWO32;
                    nx.os  = 1'b1;
                    nx.bt  = (m_cnt == OS - 1);
                    m_cnt  = (m_cnt + 1) % OS;
                end
            end
            m_sel  = baud_sel;
            nx.cnt = CW'(m_cnt);
            exp_q.push_back(nx);
        end
    end

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0; enable = 1'b0; sync_clr = 1'b0; baud_sel = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({os_tick, bit_tick, os_count} !== '0) begin
            failures++;
            $display("FAIL reset_state: got os=%0b bit=%0b cnt=%0d, expected all 0", os_tick, bit_tick, os_count);
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_reset: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_reset: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
        end
    endtask

    task automatic test_steady(input logic [2:0] sel, input int ncyc);
        exp_t   e;
        int     n_os = 0, n_bit = 0, last = -1, first = -1, lo, hi;
        longint k;
        real    exp_r;
        lo    = $rtoi(1.0e8 / (real'(rates[sel]) * 16.0));
        hi    = lo + 1;
        k     = (TWO32 + m_inc[sel] - 1) / m_inc[sel];
        exp_r = real'(ncyc) * real'(rates[sel]) * 16.0 / 1.0e8;
        baud_sel = sel;
        enable   = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_steady: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_steady: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick) begin
                n_os++;
                if (first < 0) first = c;
                else begin
                    checks++;
                    if ((c - last) != lo && (c - last) != hi) begin
                        failures++;
                        $display("FAIL spacing sel=%0d: got %0d cycles, expected %0d or %0d", sel, c - last, lo, hi);
                    end
                end
                last = c;
                if (bit_tick) begin
                    n_bit++;
                    checks++;
                    if (n_os % OS != 0) begin
                        failures++;
                        $display("FAIL bit_every_16 sel=%0d: bit_tick at os_tick #%0d, expected multiple of 16", sel, n_os);
                    end
                end
            end
        end
        checks++;
        if (first < k || first > k + 1) begin
            failures++;
            $display("FAIL first_tick sel=%0d: got cycle %0d, expected %0d..%0d", sel, first, k, k + 1);
        end
        checks++;
        if (real'(n_os) < exp_r - 1.0 || real'(n_os) > exp_r + 1.0) begin
            failures++;
            $display("FAIL os_count_total sel=%0d: got %0d, expected %f +/-1", sel, n_os, exp_r);
        end
        checks++;
        if (real'(n_bit) < exp_r / 16.0 - 1.0 || real'(n_bit) > exp_r / 16.0 + 1.0) begin
            failures++;
            $display("FAIL bit_total sel=%0d: got %0d, expected %f +/-1", sel, n_bit, exp_r / 16.0);
        end
    endtask

    task automatic test_sync_clr();
        exp_t e;
        bit   found = 1'b0;
        int   n = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_sync: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_sync: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick && os_count == 4'd9) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL sync_wait: os_count=9 not reached, got cnt=%0d", os_count);
        end
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (os_count !== 4'd0 || os_tick !== 1'b0 || bit_tick !== 1'b0) begin
            failures++;
            $display("FAIL sync_clear: got os=%0b bit=%0b cnt=%0d, expected 0 0 0", os_tick, bit_tick, os_count);
        end
        found = 1'b0;
        for (int c = 0; c < 1200 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_sync2: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_sync2: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick) n++;
            if (bit_tick) found = 1'b1;
        end
        checks++;
        if (!found || n != 16) begin
            failures++;
            $display("FAIL sync_bit_after: got %0d os_ticks (bit seen=%0b), expected 16", n, found);
        end
    endtask

    task automatic test_rate_change();
        exp_t e;
        bit   found = 1'b0;
        int   n = 0, last = -1;
        real  exp_r;
        baud_sel = 3'd0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_rate: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_rate: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick && os_count == 4'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL rate_wait: os_count=3 not reached, got cnt=%0d", os_count);
        end
        baud_sel = 3'd7;
        @(negedge clk);
        void'(exp_q.pop_front());
        checks++;
        if (os_tick !== 1'b0 || os_count !== 4'd0) begin
            failures++;
            $display("FAIL rate_clear: got os=%0b cnt=%0d, expected 0 0", os_tick, os_count);
        end
        exp_r = 300.0 * 921600.0 * 16.0 / 1.0e8;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_rate2: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_rate2: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick) begin
                n++;
                if (last >= 0) begin
                    checks++;
                    if ((c - last) != 6 && (c - last) != 7) begin
                        failures++;
                        $display("FAIL rate_spacing: got %0d cycles, expected 6 or 7", c - last);
                    end
                end
                last = c;
            end
        end
        checks++;
        if (real'(n) < exp_r - 1.0 || real'(n) > exp_r + 1.0) begin
            failures++;
            $display("FAIL rate_total: got %0d os_ticks, expected %f +/-1", n, exp_r);
        end
    endtask

    task automatic test_enable_gating();
        exp_t e;
        bit   found = 1'b0;
        bit   seen  = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_en: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_en: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick && os_count == 4'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL en_wait: os_count=5 not reached, got cnt=%0d", os_count);
        end
        enable = 1'b0;
        repeat (500) begin
            @(negedge clk);
            void'(exp_q.pop_front());
            checks++;
            if (os_tick !== 1'b0 || bit_tick !== 1'b0 || os_count !== 4'd5) begin
                failures++;
                $display("FAIL en_hold: got os=%0b bit=%0b cnt=%0d, expected 0 0 5", os_tick, bit_tick, os_count);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_en2: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_en2: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick && !seen) begin
                seen = 1'b1;
                checks++;
                if (os_count !== 4'd6) begin
                    failures++; $display("FAIL en_resume: got cnt=%0d, expected 6", os_count);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t   e;
        bit     found = 1'b0;
        int     first = 0;
        longint k;
        k = (TWO32 + m_inc[7] - 1) / m_inc[7];
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_arst: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_arst: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick && os_count != 4'd0) found = 1'b1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({os_tick, bit_tick, os_count} !== '0) begin
            failures++;
            $display("FAIL arst_immediate: got os=%0b bit=%0b cnt=%0d, expected all 0", os_tick, bit_tick, os_count);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 50 && first == 0; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sb_arst2: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({os_tick, bit_tick, os_count} !== e) begin
                    failures++;
                    $display("FAIL sb_arst2: got os=%0b bit=%0b cnt=%0d, expected os=%0b bit=%0b cnt=%0d",
                             os_tick, bit_tick, os_count, e.os, e.bt, e.cnt);
                end
            end
            if (os_tick) first = c;
        end
        checks++;
        if (first < k || first > k + 1) begin
            failures++;
            $display("FAIL arst_first_tick: got cycle %0d, expected %0d..%0d", first, k, k + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            m_inc[i] = longint'($rtoi(real'(rates[i]) * 16.0 * 4294967296.0 / 1.0e8 + 0.5));
        test_reset();
        test_steady(3'd0, 21000);
        test_steady(3'd4, 20000);
        test_sync_clr();
        test_rate_change();
        test_enable_gating();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
